// File: rtl/md_sequencer.sv
// md_sequencer: multiply/divide sequencer owning HI/LO; optional MD_HILO_FWD_EN forwards mthi/mtlo data onto rdata
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        abort,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    input  logic [31:0] wdata,
    input  logic        rd_sel,
    input  logic        md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic          pend_ok_q, pend_ok_d;
    logic          go, hilo_wr;
    logic          neg_a, neg_b;
    logic [31:0]   mag_a, mag_b, uquo, urem, quo, rem;
    logic [63:0]   prod;

    assign go      = start & ~abort & ~busy;
    assign hilo_wr = hilo_we & ~abort & ~busy & ~go;
    assign hi      = hi_q;
    assign lo      = lo_q;

    // Datapath: signed ops work on magnitudes and re-apply sign, so the
    // 0x80000000 / -1 overflow naturally yields lo = 0x80000000, hi = 0
    always_comb begin
        neg_a = op[0] & a[31];
        neg_b = op[0] & b[31];
        mag_a = neg_a ? -a : a;
        mag_b = neg_b ? -b : b;
        uquo  = (mag_b == '0) ? '0 : mag_a / mag_b;
        urem  = (mag_b == '0) ? '0 : mag_a % mag_b;
        quo   = (neg_a ^ neg_b) ? -uquo : uquo;
        rem   = neg_a ? -urem : urem;
        prod  = {{32{neg_a}}, a} * {{32{neg_b}}, b};
    end

    // State register: busy counter, architectural HI/LO and latched pending result
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_ok_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_ok_q <= pend_ok_d;
        end
    end

    // Next state: issue latches the result, busy counts down and commits on the
    // last cycle (skipped for divide by zero), idle accepts mthi/mtlo
    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_ok_d = pend_ok_q;
        if (go) begin
            cnt_d     = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            pend_hi_d = op[1] ? rem : prod[63:32];
            pend_lo_d = op[1] ? quo : prod[31:0];
            pend_ok_d = ~op[1] | (b != '0);
        end else if (busy) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1) && pend_ok_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else if (hilo_wr) begin
            hi_d = hilo_sel ? wdata : hi_q;
            lo_d = hilo_sel ? lo_q : wdata;
        end
    end

    // Outputs: busy flag, decode stall request and mfhi/mflo read mux
    always_comb begin
        busy  = cnt_q != '0;
        stall = md_use & (busy | (start & ~abort));
`ifdef MD_HILO_FWD_EN
        rdata = (hilo_we & ~abort & ~busy & (hilo_sel == rd_sel)) ? wdata : (rd_sel ? hi_q : lo_q);
`else
        rdata = rd_sel ? hi_q : lo_q;
`endif
    end
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed scenarios plus randomized traffic checked against a cycle-level reference model
module tb_md_sequencer;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset, start, abort, hilo_we, hilo_sel, rd_sel, md_use;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, stall;
    logic [31:0] hi, lo, rdata;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    bit          m_pok;
    int          m_rem;

    always #5 clk = ~clk;

    md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .abort(abort), .hilo_we(hilo_we), .hilo_sel(hilo_sel), .wdata(wdata),
        .rd_sel(rd_sel), .md_use(md_use), .busy(busy), .stall(stall),
        .hi(hi), .lo(lo), .rdata(rdata)
    );

    task automatic calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] rh, output logic [31:0] rl, output bit ok);
        longint sx, sy, p, q, r;
        sx = o[0] ? longint'($signed(x)) : longint'({32'h0, x});
        sy = o[0] ? longint'($signed(y)) : longint'({32'h0, y});
        ok = 1;
        rh = 0;
        rl = 0;
        if (!o[1]) begin
            p = sx * sy;
            rh = p[63:32];
            rl = p[31:0];
        end else if (y == 0) begin
            ok = 0;
        end else begin
            q = sx / sy;
            r = sx % sy;
            rh = r[31:0];
            rl = q[31:0];
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        if (reset) begin
            m_hi = 0; m_lo = 0; m_rem = 0; m_pok = 0; m_phi = 0; m_plo = 0;
        end else if (start && !abort && m_rem == 0) begin
            calc(op, a, b, m_phi, m_plo, m_pok);
            m_rem = op[1] ? DC : MC;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && m_pok) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (hilo_we && !abort) begin
            if (hilo_sel) m_hi = wdata;
            else m_lo = wdata;
        end
        @(negedge clk);
    endtask

    task automatic idle;
        reset = 0; start = 0; abort = 0; hilo_we = 0; md_use = 0;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int n);
        start = 1; op = o; a = x; b = y;
        cyc();
        start = 0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            cyc();
        end
    endtask

    task automatic test_reset;
        reset = 1;
        cyc();
        cyc();
        reset = 0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got %h want 0", lo); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got %b want 0", stall); end
    endtask

    task automatic test_mult;
        int n;
        run_op(2'b01, 32'hFFFFFFFE, 32'd3, n);
        checks++; if (n != MC) begin failures++; $display("FAIL mult_busy_len got %0d want %0d", n, MC); end
        checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFFA) begin failures++; $display("FAIL mult_lo got %h want fffffffa", lo); end
    endtask

    task automatic test_div;
        int n;
        run_op(2'b11, 32'hFFFFFFF9, 32'd2, n);
        checks++; if (n != DC) begin failures++; $display("FAIL div_busy_len got %0d want %0d", n, DC); end
        checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi got %h want ffffffff", hi); end
        run_op(2'b10, 32'd1234, 32'd0, n);
        checks++; if (n != DC) begin failures++; $display("FAIL divz_busy_len got %0d want %0d", n, DC); end
        checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL divz_keep got %h/%h want ffffffff/fffffffd", hi, lo); end
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, n);
        checks++; if (hi !== 32'h0 || lo !== 32'h80000000) begin failures++; $display("FAIL div_ovf got %h/%h want 00000000/80000000", hi, lo); end
    endtask

    task automatic test_stall;
        int n, s;
        md_use = 1; rd_sel = 0; s = 0; n = 0;
        start = 1; op = 2'b00; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        #1;
        if (stall === 1'b1) s++;
        cyc();
        start = 0;
        while (busy === 1'b1 && n < 40) begin
            #1;
            if (stall === 1'b1) s++;
            n++;
            cyc();
        end
        #1;
        checks++; if (s != MC + 1) begin failures++; $display("FAIL stall_len got %0d want %0d", s, MC + 1); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL stall_end got %b want 0", stall); end
        checks++; if (rdata !== 32'h1) begin failures++; $display("FAIL multu_rdata got %h want 00000001", rdata); end
        checks++; if (hi !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_hi got %h want fffffffe", hi); end
        md_use = 0;
    endtask

    task automatic test_busy_ignore;
        int n;
        start = 1; op = 2'b01; a = 32'd7; b = 32'd6;
        cyc();
        start = 0;
        cyc();
        hilo_we = 1; hilo_sel = 1; wdata = 32'h12345678;
        start = 1; op = 2'b11; a = 32'd100; b = 32'd7;
        cyc();
        idle();
        n = 2;
        while (busy === 1'b1 && n < 40) begin
            n++;
            cyc();
        end
        checks++; if (n != MC) begin failures++; $display("FAIL ignore_len got %0d want %0d", n, MC); end
        checks++; if (hi !== 32'h0 || lo !== 32'd42) begin failures++; $display("FAIL ignore_result got %h/%h want 00000000/0000002a", hi, lo); end
    endtask

    task automatic test_back_to_back;
        int n;
        hilo_we = 1; hilo_sel = 1; wdata = 32'hDEADBEEF;
        run_op(2'b00, 32'd2, 32'd3, n);
        hilo_we = 0;
        checks++; if (hi !== 32'h0 || lo !== 32'd6) begin failures++; $display("FAIL we_with_go got %h/%h want 00000000/00000006", hi, lo); end
        hilo_we = 1; hilo_sel = 1; wdata = 32'h55AA55AA;
        cyc();
        hilo_we = 0; rd_sel = 1;
        #1;
        checks++; if (rdata !== 32'h55AA55AA) begin failures++; $display("FAIL mthi got %h want 55aa55aa", rdata); end
    endtask

    task automatic test_abort;
        logic [31:0] ph, pl;
        ph = hi; pl = lo;
        start = 1; abort = 1; op = 2'b01; a = 32'd9; b = 32'd9;
        hilo_we = 1; hilo_sel = 0; wdata = 32'h0BADF00D;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL abort_stall got %b want 0", stall); end
        cyc();
        idle();
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (hi !== ph || lo !== pl) begin failures++; $display("FAIL abort_keep got %h/%h want %h/%h", hi, lo, ph, pl); end
    endtask

    task automatic test_reset_mid;
        start = 1; op = 2'b01; a = 32'd3; b = 32'd5;
        cyc();
        start = 0;
        cyc();
        cyc();
        reset = 1;
        cyc();
        reset = 0;
        #1;
        checks++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin failures++; $display("FAIL reset_mid got busy=%b %h/%h want 0 0/0", busy, hi, lo); end
        repeat (6) cyc();
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_discard got %h want 0", lo); end
    endtask

    task automatic test_mtlo;
        hilo_we = 1; hilo_sel = 0; wdata = 32'hCAFEF00D; rd_sel = 0;
        #1;
`ifdef MD_HILO_FWD_EN
        checks++; if (rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL mtlo_fwd got %h want cafef00d", rdata); end
`else
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL mtlo_nofwd got %h want 00000000", rdata); end
`endif
        cyc();
        hilo_we = 0;
        #1;
        checks++; if (rdata !== 32'hCAFEF00D || lo !== 32'hCAFEF00D) begin failures++; $display("FAIL mtlo_next got %h/%h want cafef00d", rdata, lo); end
    endtask

    task automatic test_random;
        logic [31:0] er;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            start = ($urandom_range(0, 4) == 0);
            abort = ($urandom_range(0, 7) == 0);
            op = 2'($urandom);
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            hilo_we = ($urandom_range(0, 2) == 0);
            hilo_sel = 1'($urandom);
            wdata = $urandom;
            rd_sel = 1'($urandom);
            md_use = 1'($urandom);
            #1;
`ifdef MD_HILO_FWD_EN
            er = (hilo_we && !abort && m_rem == 0 && hilo_sel == rd_sel) ? wdata : (rd_sel ? m_hi : m_lo);
`else
            er = rd_sel ? m_hi : m_lo;
`endif
            checks++; if (busy !== (m_rem > 0)) begin failures++; $display("FAIL rnd_busy[%0d] got %b want %b", i, busy, m_rem > 0); end
            checks++; if (stall !== (md_use && (m_rem > 0 || (start && !abort)))) begin failures++; $display("FAIL rnd_stall[%0d] got %b", i, stall); end
            checks++; if (hi !== m_hi) begin failures++; $display("FAIL rnd_hi[%0d] got %h want %h", i, hi, m_hi); end
            checks++; if (lo !== m_lo) begin failures++; $display("FAIL rnd_lo[%0d] got %h want %h", i, lo, m_lo); end
            checks++; if (rdata !== er) begin failures++; $display("FAIL rnd_rdata[%0d] got %h want %h", i, rdata, er); end
            cyc();
        end
        idle();
    endtask

    initial begin
        reset = 1; start = 0; abort = 0; hilo_we = 0; hilo_sel = 0; rd_sel = 0; md_use = 0;
        op = 0; a = 0; b = 0; wdata = 0;
        m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pok = 0; m_rem = 0;
        @(negedge clk);
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_busy_ignore();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_mtlo();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
